uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- Serial UART receiver sitting directly upstream of the boot loader's byte-parsing logic.
- Converts the asynchronous rx pin (8N1, LSB first) into bytes.
- Presents each byte on a valid/ready handshake, with framing-error and overrun reporting.
- Runs on the system clock, gated by the shared clock-enable ce.

Parameters:
- CLKS_PER_BIT, 87, ce-qualified clock cycles per bit period (10 MHz / 115200); legal range 8..65535.
- CNT_W, 16, width of the bit-period counter; must satisfy 2**CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- ce  input  1  clock enable; when 0 all state holds.
- rx  input  1  asynchronous serial input, idle high.
- dout  output  8  received byte.
- dout_valid  output  1  dout holds an unconsumed byte.
- dout_ready  input  1  consumer accepts dout.
- busy  output  1  high whenever FSM is not IDLE.
- framing_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: byte completed while previous byte still unconsumed.
- parity_err  output  1  one-cycle pulse; tied 0 unless UART_RX_PARITY_EN is defined.

Behaviour:
- Reset (async, active-high):
  - dout=0x00; dout_valid, busy, framing_err, overrun, parity_err all 0.
  - FSM=IDLE; counters=0; both synchronizer flops=1.
- Gating:
  - All registers update only on cycles with ce=1, except async reset.
  - With ce=0 nothing changes, including the synchronizer and pulse outputs (pulses stretch over ce=0 cycles).
- Input path:
  - rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s.
  - Adds 2 ce-cycles of latency.
- FSM states:
  - IDLE: on rx_s=0, go to START, clear counter.
  - START:
    - Count to CLKS_PER_BIT/2 - 1 (integer division).
    - At that point, if rx_s=0, go to DATA with counter and bit index cleared.
    - If rx_s=1, treat as a glitch and return to IDLE; no output activity.
  - DATA:
    - Count to CLKS_PER_BIT-1, then sample rx_s into shift bit[index] (LSB first).
    - Clear counter; index 0..7; after index 7 go to STOP (PARITY when enabled).
  - STOP:
    - Count to CLKS_PER_BIT-1, then sample.
    - If sample is 1, deliver the byte (see handshake) and go to IDLE.
    - If sample is 0, pulse framing_err, discard the byte, and go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. A held-low line produces exactly one framing_err.
- Delivery timing: on the stop-sample cycle, the byte is registered; dout_valid=1 from the next cycle.
- Handshake:
  - Transfer occurs on any ce cycle with dout_valid=1 and dout_ready=1; dout_valid clears next cycle unless a new byte loads that same cycle.
  - dout is stable while dout_valid=1 and no transfer has occurred.
  - New byte completing while dout_valid=1 and dout_ready=0: overrun pulses; the new byte is dropped; the old dout and dout_valid are retained.
  - New byte completing on the same cycle as a transfer: new byte loads, dout_valid stays 1, no overrun.
- Reset mid-frame: everything returns to reset values immediately; a partial frame is lost. After reset deasserts, reception restarts only on the next falling edge of rx_s.
- dout_ready is ignored while dout_valid=0.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, sampled at CLKS_PER_BIT-1; even parity is expected.
  - On mismatch, parity_err pulses in the stop-sample cycle, and only when the stop bit is 1.
  - The byte is still delivered.
- When undefined: no PARITY state; parity_err is constant 0; frame is 8N1.

Test Plan:
- CLKS_PER_BIT=16, ce=1, send 0xA5 8N1 → dout=0xA5 with dout_valid=1 held while dout_ready=0; after ready is asserted for 1 cycle, dout_valid=0.
- rx low pulse of 4 cycles (< CLKS_PER_BIT/2) → busy rises then returns to 0; dout_valid, framing_err, overrun all remain 0.
- Send 0x3C with stop bit driven 0, line then held low 100 bit-times → exactly one framing_err pulse, no dout_valid; next valid frame 0x55 received correctly.
- Send 0x11 then 0x22 with dout_ready=0 → one overrun pulse at the second stop sample; dout=0x11 retained. Repeat with ready asserted exactly on the 0x22 load cycle → dout=0x22, no overrun.
- ce toggling 1/0 every cycle, send 0x80 → byte received correctly, taking 2x the wall-clock time of the ce=1 case.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong) → parity_err pulse, dout=0x07 delivered; with parity bit 1 → no parity_err.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with valid/ready byte output, framing-error and overrun pulses.
// Optional even-parity frame (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       framing_err,
    output logic       overrun,
    output logic       parity_err
);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;
    logic             rx_meta_q, rx_s_q;
    logic             xfer;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             pe_q, pe_d;
`endif

    assign xfer = valid_q & dout_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        pe_d    = 1'b0;
`endif
        if (xfer) valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    shift_d[idx_q] = rx_s_q;
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_d = S_PARITY;
`else
                    if (idx_q == 3'd7) state_d = S_STOP;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    par_d   = rx_s_q;
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        // A byte may load into the slot being consumed this cycle.
                        if (!valid_q || xfer) begin
                            dout_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        pe_d = par_q ^ (^shift_q);
`endif
                    end else begin
                        state_d = S_BREAK;
                        fe_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            pe_q      <= 1'b0;
`endif
        end else if (ce) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            pe_q      <= pe_d;
`endif
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = valid_q;
    assign busy        = (state_q != S_IDLE);
    assign framing_err = fe_q;
    assign overrun     = ov_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = pe_q;
`else
    assign parity_err  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: scoreboard queue of expected bytes, pulse counters
// sampled on the falling clock edge.
module tb_uart_rx_byte;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst, ce, rx, dout_ready;
    logic [7:0] dout;
    logic       dout_valid, busy, framing_err, overrun, parity_err;

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ce(ce), .rx(rx),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .framing_err(framing_err), .overrun(overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int tcnt = 0, t_start = 0, vld_rise_t = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, busy_rise = 0;
    logic fe_p = 0, ov_p = 0, pe_p = 0, busy_p = 0, vld_p = 0;
    bit ce_tog = 0;
    logic [7:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One falling edge: sample outputs, count pulse rising edges, optionally toggle ce.
    task automatic tick();
        @(negedge clk);
        tcnt++;
        if (framing_err && !fe_p) fe_cnt++;
        if (overrun && !ov_p) ov_cnt++;
        if (parity_err && !pe_p) pe_cnt++;
        if (busy && !busy_p) busy_rise++;
        if (dout_valid && !vld_p) vld_rise_t = tcnt;
        fe_p = framing_err; ov_p = overrun; pe_p = parity_err;
        busy_p = busy; vld_p = dout_valid;
        if (ce_tog) ce = ~ce;
    endtask

    // par < 0: 8N1 frame; otherwise par is the parity bit value. rdy_t >= 0 drives
    // dout_ready high only on that tick offset from the start edge.
    task automatic send(input logic [7:0] d, input logic stop, input int par,
                        input int cpb, input int rdy_t);
        logic [10:0] fr;
        int nb;
        if (par < 0) begin
            fr = {1'b1, stop, d, 1'b0};
            nb = 10;
        end else begin
            fr = {stop, par[0], d, 1'b0};
            nb = 11;
        end
        t_start = tcnt;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < cpb; c++) begin
                rx = fr[i];
                if (rdy_t >= 0) dout_ready = ((i * cpb + c) == rdy_t);
                tick();
            end
        end
        rx = 1'b1;
    endtask

    task automatic wait_vld(input string tag);
        for (int i = 0; i < 400 && !dout_valid; i++) tick();
        chk(tag, dout_valid, 1);
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk(tag, dout, e);
        end
    endtask

    task automatic consume();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; rx = 1'b1; dout_ready = 1'b0;
        idle(3);
        chk("rst_dout", dout, 8'h00);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fe", framing_err, 0);
        chk("rst_ov", overrun, 0);
        chk("rst_pe", parity_err, 0);
        rst = 1'b0;
        idle(5);

        // 0xA5: held while ready low, cleared after one ready cycle
        sb_q.push_back(8'hA5);
        send(8'hA5, 1'b1, -1, CPB, -1);
        chk("a5_latency", vld_rise_t - t_start, 155);
        wait_vld("a5_valid");
        idle(20);
        chk("a5_hold_valid", dout_valid, 1);
        pop_chk("a5_dout");
        consume();
        chk("a5_cleared", dout_valid, 0);

        // short low glitch
        busy_rise = 0; fe_cnt = 0; ov_cnt = 0;
        rx = 1'b0; idle(4); rx = 1'b1; idle(30);
        chk("glitch_busy_rose", busy_rise, 1);
        chk("glitch_busy_end", busy, 0);
        chk("glitch_valid", dout_valid, 0);
        chk("glitch_fe", fe_cnt, 0);
        chk("glitch_ov", ov_cnt, 0);

        // framing error then held-low break
        fe_cnt = 0;
        send(8'h3C, 1'b0, -1, CPB, -1);
        rx = 1'b0; idle(100 * CPB);
        rx = 1'b1; idle(40);
        chk("brk_fe_once", fe_cnt, 1);
        chk("brk_no_valid", dout_valid, 0);
        chk("brk_idle", busy, 0);
        sb_q.push_back(8'h55);
        send(8'h55, 1'b1, -1, CPB, -1);
        wait_vld("rec55_valid");
        pop_chk("rec55_dout");
        consume();

        // overrun: 0x22 dropped, 0x11 retained
        ov_cnt = 0;
        sb_q.push_back(8'h11);
        send(8'h11, 1'b1, -1, CPB, -1);
        send(8'h22, 1'b1, -1, CPB, -1);
        chk("ovr_pulse", ov_cnt, 1);
        chk("ovr_valid", dout_valid, 1);
        pop_chk("ovr_dout_kept");
        consume();
        idle(5);

        // transfer on the exact load cycle of the next byte
        sb_q.push_back(8'h11);
        send(8'h11, 1'b1, -1, CPB, -1);
        wait_vld("same_first_valid");
        pop_chk("same_first_dout");
        ov_cnt = 0;
        sb_q.push_back(8'h22);
        send(8'h22, 1'b1, -1, CPB, 154);
        chk("same_no_ovr", ov_cnt, 0);
        chk("same_valid", dout_valid, 1);
        pop_chk("same_dout");
        consume();
        chk("same_cleared", dout_valid, 0);

        // ce at half rate
        ce_tog = 1'b1;
        sb_q.push_back(8'h80);
        send(8'h80, 1'b1, -1, 2 * CPB, -1);
        ce_tog = 1'b0; ce = 1'b1;
        chk("ce_half_latency", ((vld_rise_t - t_start) >= 306) && ((vld_rise_t - t_start) <= 314), 1);
        wait_vld("ce_half_valid");
        pop_chk("ce_half_dout");
        consume();
        idle(5);

`ifdef UART_RX_PARITY_EN
        pe_cnt = 0;
        sb_q.push_back(8'h07);
        send(8'h07, 1'b1, 0, CPB, -1);
        chk("par_bad_pulse", pe_cnt, 1);
        wait_vld("par_bad_valid");
        pop_chk("par_bad_dout");
        consume();
        pe_cnt = 0;
        sb_q.push_back(8'h07);
        send(8'h07, 1'b1, 1, CPB, -1);
        chk("par_ok_nopulse", pe_cnt, 0);
        wait_vld("par_ok_valid");
        pop_chk("par_ok_dout");
        consume();
`else
        pe_cnt = 0;
        idle(2);
        chk("par_tied0", parity_err, 0);
`endif

        // reset mid-frame
        rx = 1'b0; idle(60);
        chk("mid_busy", busy, 1);
        rst = 1'b1; tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", dout_valid, 0);
        rx = 1'b1; rst = 1'b0; idle(40);
        chk("mid_after_busy", busy, 0);
        chk("mid_after_valid", dout_valid, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
